// File: rtl/send_queue_pkg.sv
// Shared constants, arbiter state type and status-word layout for the send queue arbiter.
package send_queue_pkg;

  localparam int unsigned DefaultNch      = 4;
  localparam int unsigned DefaultDepth    = 8;
  localparam int unsigned DefaultDw       = 256;
  localparam int unsigned DefaultMaxBurst = 4;

  typedef enum logic [0:0] {
    IDLE,
    HOLD
  } arb_state_e;

  // Status word: {zeros, ovf, level}; level is log2(depth)+1 bits wide starting at bit 0.
  localparam int unsigned StatLevelLsb = 0;

  function automatic int unsigned stat_ovf_bit(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sq_fifo.sv
// Single-clock show-ahead FIFO; the head word is presented combinationally from storage.
module sq_fifo
  import send_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned DW    = DefaultDw
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          dataIn,
  output logic [DW-1:0]          dataOut,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          push_ok, pop_ok;

  // Full is judged before any same-cycle pop, so a push to a full FIFO is always dropped.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PtrOne;
      if (pop_ok)  rd_q <= rd_q + PtrOne;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= dataIn;
  end

  assign level   = wr_q - rd_q;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign dataOut = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/send_queue_arb.sv
// Per-channel send FIFOs with a burst-limited arbiter on the consumer side.
// Define SEND_QUEUE_RR_EN for round-robin arbitration; otherwise lowest index wins.
module send_queue_arb
  import send_queue_pkg::*;
#(
  parameter int unsigned NCH      = DefaultNch,
  parameter int unsigned DEPTH    = DefaultDepth,
  parameter int unsigned DW       = DefaultDw,
  parameter int unsigned MAXBURST = DefaultMaxBurst
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [9:0]             address,
  input  logic                   chipselect,
  input  logic                   write,
  input  logic [DW-1:0]          writedata,
  input  logic [DW/8-1:0]        byteenable,
  output logic [DW-1:0]          readdata,
  output logic [DW-1:0]          dataOut,
  output logic [$clog2(NCH)-1:0] chanOut,
  output logic                   ready,
  input  logic                   dataPop,
  output logic [NCH-1:0]         emptyArray,
  output logic [NCH-1:0]         fullArray
);

  localparam int unsigned CW     = $clog2(NCH);
  localparam int unsigned LW     = $clog2(DEPTH) + 1;
  localparam int unsigned CntW   = $clog2(MAXBURST + 1);
  localparam int unsigned OvfBit = stat_ovf_bit(DEPTH);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]  ovf_q, ovf_d;
  logic [DW-1:0]   rd_q, rd_d;

  logic [CW-1:0]   ch;
  logic            wr_req, rd_req, drop, do_pop, held_left, burst_done;
  logic [NCH-1:0]  push_vec, pop_vec, cand;
  logic [CW-1:0]   win;
  logic [LW-1:0]   level [NCH];
  logic [DW-1:0]   fdata [NCH];
  logic            unused_in;

  // Every push stores the whole word, so byte enables and the unused address bits are ignored.
  assign unused_in = ^{byteenable, address};

  assign ch     = address[3 +: CW];
  assign wr_req = chipselect & write;
  assign rd_req = chipselect & ~write;
  assign drop   = wr_req & fullArray[ch];

  assign ready  = (state_q == HOLD) & ~emptyArray[chan_q];
  assign do_pop = ready & dataPop;

  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    for (int i = 0; i < NCH; i++) begin
      push_vec[i] = wr_req && (ch == CW'(i)) && !fullArray[i];
      pop_vec[i]  = do_pop && (chan_q == CW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_fifo
    sq_fifo #(
      .DEPTH(DEPTH),
      .DW   (DW)
    ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .push   (push_vec[g]),
      .pop    (pop_vec[g]),
      .dataIn (writedata),
      .dataOut(fdata[g]),
      .full   (fullArray[g]),
      .empty  (emptyArray[g]),
      .level  (level[g])
    );
  end

  assign dataOut = fdata[chan_q];
  assign chanOut = chan_q;

  // Candidates reflect the held channel's occupancy after this cycle's pop and push.
  assign held_left  = (level[chan_q] != LW'(1)) | push_vec[chan_q];
  assign burst_done = (cnt_q + CntW'(1)) == CntW'(MAXBURST);

  always_comb begin
    cand = ~emptyArray;
    if (do_pop) cand[chan_q] = held_left;
  end

`ifdef SEND_QUEUE_RR_EN
  always_comb begin : p_pick
    logic [CW-1:0] idx;
    idx = '0;
    win = chan_q;
    // Descending scan so the nearest channel after the last grant wins; k=NCH is chan_q itself.
    for (int k = NCH; k >= 1; k--) begin
      idx = chan_q + CW'(k);
      if (cand[idx]) win = idx;
    end
  end
`else
  always_comb begin : p_pick
    win = chan_q;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) win = CW'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          state_d = HOLD;
          chan_d  = win;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (do_pop) begin
          if (!held_left || burst_done) begin
            cnt_d = '0;
            if (|cand) chan_d = win;
            else state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (rd_req) ovf_d[ch] = 1'b0;
    if (drop)   ovf_d[ch] = 1'b1;
  end

  always_comb begin
    rd_d = rd_q;
    if (rd_req) begin
      rd_d = '0;
      rd_d[StatLevelLsb +: LW] = level[ch];
      rd_d[OvfBit]             = ovf_q[ch];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      chan_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end

  assign readdata = rd_q;

endmodule

// File: tb/tb_send_queue_arb.sv
// Directed self-checking bench for send_queue_arb; expected burst order follows SEND_QUEUE_RR_EN.
module tb_send_queue_arb;

  localparam int unsigned NCH      = 4;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned DW       = 256;
  localparam int unsigned MAXBURST = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [9:0]      address;
  logic            chipselect;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   readdata;
  logic [DW-1:0]   dataOut;
  logic [1:0]      chanOut;
  logic            ready;
  logic            dataPop;
  logic [NCH-1:0]  emptyArray;
  logic [NCH-1:0]  fullArray;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  send_queue_arb #(
    .NCH     (NCH),
    .DEPTH   (DEPTH),
    .DW      (DW),
    .MAXBURST(MAXBURST)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write     (write),
    .writedata (writedata),
    .byteenable(byteenable),
    .readdata  (readdata),
    .dataOut   (dataOut),
    .chanOut   (chanOut),
    .ready     (ready),
    .dataPop   (dataPop),
    .emptyArray(emptyArray),
    .fullArray (fullArray)
  );

  function automatic logic [DW-1:0] mkword(input int c, input int i);
    return {32'(c) ^ 32'hc0de_0000, 192'h0, 32'(i)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    chipselect = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '1;
    dataPop    = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input int c, input int i);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 10'(c << 3);
    writedata  = mkword(c, i);
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic read_status(input int c);
    chipselect = 1'b1;
    write      = 1'b0;
    address    = 10'(c << 3);
    tick();
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0", ready);
    end
    checks++;
    if (chanOut !== 2'd0) begin
      errors++; $display("FAIL reset_chan got %0d want 0", chanOut);
    end
    checks++;
    if ({emptyArray, fullArray} !== 8'hf0) begin
      errors++; $display("FAIL reset_flags got %h/%h want f/0", emptyArray, fullArray);
    end
    checks++;
    if (readdata !== '0) begin
      errors++; $display("FAIL reset_readdata got %h want 0", readdata);
    end
  endtask

  // Three pushes to ch2 with dataPop held high from the first cycle.
  task automatic test_single_channel();
    do_reset();
    dataPop    = 1'b1;
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 10'(2 << 3);
    writedata  = mkword(2, 0);
    tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL single_c1_ready got %b want 0", ready);
    end
    writedata = mkword(2, 1);
    tick();
    checks++;
    if ({ready, chanOut, dataOut} !== {1'b1, 2'd2, mkword(2, 0)}) begin
      errors++; $display("FAIL single_c2 got r=%b ch=%0d d=%h want r=1 ch=2 d=%h",
                         ready, chanOut, dataOut, mkword(2, 0));
    end
    writedata = mkword(2, 2);
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    checks++;
    if ({ready, dataOut} !== {1'b1, mkword(2, 1)}) begin
      errors++; $display("FAIL single_c3 got r=%b d=%h want d=%h", ready, dataOut, mkword(2, 1));
    end
    tick();
    checks++;
    if ({ready, dataOut} !== {1'b1, mkword(2, 2)}) begin
      errors++; $display("FAIL single_c4 got r=%b d=%h want d=%h", ready, dataOut, mkword(2, 2));
    end
    tick();
    checks++;
    if ({ready, emptyArray} !== 5'b0_1111) begin
      errors++; $display("FAIL single_idle got r=%b e=%h want r=0 e=f", ready, emptyArray);
    end
    dataPop = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) push(0, i);
    checks++;
    if ({fullArray, emptyArray} !== 8'h1e) begin
      errors++; $display("FAIL ovf_full got f=%h e=%h want 1/e", fullArray, emptyArray);
    end
    push(0, 8);
    checks++;
    if ({ready, chanOut, dataOut} !== {1'b1, 2'd0, mkword(0, 0)}) begin
      errors++; $display("FAIL ovf_head got r=%b ch=%0d d=%h want r=1 ch=0 d=%h",
                         ready, chanOut, dataOut, mkword(0, 0));
    end
    read_status(0);
    checks++;
    if (readdata !== 256'h18) begin
      errors++; $display("FAIL ovf_read1 got %h want 18", readdata);
    end
    read_status(0);
    checks++;
    if (readdata !== 256'h08) begin
      errors++; $display("FAIL ovf_read2 got %h want 08", readdata);
    end
  endtask

  task automatic test_burst();
    int exp_ch [12];
    int exp_i  [12];
`ifdef SEND_QUEUE_RR_EN
    exp_ch = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    exp_i  = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 4, 5};
`else
    exp_ch = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    exp_i  = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
`endif
    do_reset();
    for (int i = 0; i < 6; i++) push(0, i);
    for (int i = 0; i < 6; i++) push(1, i);
    dataPop = 1'b1;
    for (int n = 0; n < 12; n++) begin
      checks++;
      if ({ready, chanOut, dataOut} !== {1'b1, 2'(exp_ch[n]), mkword(exp_ch[n], exp_i[n])}) begin
        errors++; $display("FAIL burst_%0d got r=%b ch=%0d d=%h want r=1 ch=%0d d=%h", n,
                           ready, chanOut, dataOut, exp_ch[n], mkword(exp_ch[n], exp_i[n]));
      end
      tick();
    end
    checks++;
    if ({ready, emptyArray} !== 5'b0_1111) begin
      errors++; $display("FAIL burst_end got r=%b e=%h want r=0 e=f", ready, emptyArray);
    end
    dataPop = 1'b0;
  endtask

  task automatic test_push_pop_same();
    do_reset();
    push(3, 0);
    tick();
    checks++;
    if ({ready, chanOut} !== {1'b1, 2'd3}) begin
      errors++; $display("FAIL pp_grant got r=%b ch=%0d want r=1 ch=3", ready, chanOut);
    end
    dataPop = 1'b1;
    push(3, 1);
    dataPop = 1'b0;
    checks++;
    if ({ready, chanOut, dataOut, emptyArray} !== {1'b1, 2'd3, mkword(3, 1), 4'b0111}) begin
      errors++; $display("FAIL pp_head got r=%b ch=%0d d=%h e=%h want d=%h e=7",
                         ready, chanOut, dataOut, emptyArray, mkword(3, 1));
    end
    read_status(3);
    checks++;
    if (readdata !== 256'h01) begin
      errors++; $display("FAIL pp_status got %h want 01", readdata);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 5; i++) push(1, i);
    read_status(1);
    checks++;
    if (readdata !== 256'h05) begin
      errors++; $display("FAIL mid_status got %h want 05", readdata);
    end
    dataPop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ready, chanOut, dataOut} !== {1'b1, 2'd1, mkword(1, i)}) begin
        errors++; $display("FAIL mid_pop%0d got r=%b ch=%0d d=%h want d=%h", i,
                           ready, chanOut, dataOut, mkword(1, i));
      end
      tick();
    end
    dataPop = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({ready, chanOut, emptyArray, fullArray} !== {1'b0, 2'd0, 4'hf, 4'h0}) begin
      errors++; $display("FAIL mid_reset got r=%b ch=%0d e=%h f=%h want r=0 ch=0 e=f f=0",
                         ready, chanOut, emptyArray, fullArray);
    end
    checks++;
    if (readdata !== '0) begin
      errors++; $display("FAIL mid_reset_rd got %h want 0", readdata);
    end
    tick();
    checks++;
    if ({ready, emptyArray} !== 5'b0_1111) begin
      errors++; $display("FAIL mid_after got r=%b e=%h want r=0 e=f", ready, emptyArray);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_channel();
    test_overflow();
    test_burst();
    test_push_pop_same();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/send_queue_arb.md
SEND_QUEUE_ARB -- requirements
Module: send_queue_arb

Interface
REQ-001 Parameter NCH, default 4: number of channel FIFOs; power of two, 2..16.
REQ-002 Parameter DEPTH, default 8: entries per channel FIFO; power of two, 4..64.
REQ-003 Parameter DW, default 256: data width.
REQ-004 Parameter MAXBURST, default 4: maximum consecutive pops from one channel before re-arbitration; 1..DEPTH.
REQ-005 clock  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 address  in  10  PCIe-side word address; channel = address[3 +: log2(NCH)].
REQ-008 chipselect, write  in  1 each  PCIe-side access qualifiers.
REQ-009 writedata  in  DW  push data.
REQ-010 byteenable  in  DW/8  accepted but ignored; every push stores the full word.
REQ-011 readdata  out  DW  status of the addressed channel.
REQ-012 dataOut  out  DW  head word of the granted channel.
REQ-013 chanOut  out  log2(NCH)  granted channel index.
REQ-014 ready  out  1  the granted channel is non-empty.
REQ-015 dataPop  in  1  consumer pop; takes effect only when ready=1.
REQ-016 emptyArray, fullArray  out  NCH each  per-channel flags.

Function
REQ-017 Push rule: chipselect&write&~fullArray[ch] writes writedata into FIFO ch.
- The word is visible at the FIFO head on the next cycle.
REQ-018 Push to a full channel:
- the word is dropped;
- sticky ovf[ch] is set.
REQ-019 Read rule: chipselect&~write latches readdata on the next cycle.
- readdata = {zeros, ovf[ch], level[ch]}, where level is log2(DEPTH)+1 bits wide.
- The read clears ovf[ch], unless a dropped push to ch occurs in the same cycle; that push wins.
REQ-020 FIFOs are show-ahead: dataOut = head of FIFO chanOut, combinational from registered state.
REQ-021 Pop rule: dataPop&ready removes one word from chanOut.
- dataPop while ready=0 has no effect.
REQ-022 A simultaneous push and pop on the same channel are both honoured.
- Level is unchanged.
- Pushing to a full channel while it is popped is still dropped; full is evaluated pre-pop.
REQ-023 Arbiter states:
- IDLE: no grant held; ready=0.
- HOLD: chanOut fixed; burst counter counts pops.
REQ-024 IDLE -> HOLD when any channel is non-empty.
- The winner is registered; ready rises one cycle later.
REQ-025 HOLD -> re-arbitrate (no IDLE bubble) when either:
- a pop empties the channel; or
- the pop count reaches MAXBURST.
- If no other channel is non-empty and the held channel is still non-empty, the same channel is re-granted and the count resets.
- If all channels are empty, go to IDLE.
REQ-026 chanOut and dataOut never change in a cycle where ready=1 and dataPop=0.
REQ-027 Words within a channel are popped in push order; no ordering holds between channels.

Reset
REQ-028 Reset values:
- all FIFOs empty (emptyArray all ones, fullArray 0);
- ovf cleared;
- state IDLE, chanOut=0, ready=0, readdata=0, burst count 0.
REQ-029 Reset asserted mid-burst discards all stored data on the next edge.

Configuration
REQ-030 Macro SEND_QUEUE_RR_EN selects the arbitration policy.
- Defined: round-robin; search starts at last granted channel +1, modulo NCH.
- Undefined: fixed priority; lowest non-empty index wins.
- All other behaviour is identical in both builds.

Structure
REQ-031 Package send_queue_pkg holds:
- the default parameter constants;
- the arbiter state enum {IDLE, HOLD};
- the status-word field offsets.
REQ-032 Sub-module sq_fifo provides one synchronous show-ahead FIFO.
- Ports: push, pop, dataIn, dataOut, full, empty, level.
- Instantiated NCH times by generate.

Verification
REQ-033 Push 3 words to ch2, hold dataPop=1 -> ready at cycle 2, chanOut=2, the 3 words out in order, then IDLE.
REQ-034 Fill ch0 with 8 words, push a 9th, then read ch0 status:
- readdata level=8, ovf=1;
- a second read returns ovf=0.
REQ-035 ch0 and ch1 each hold 6 words, MAXBURST=4, dataPop constant:
- order ch0×4, ch1×4, ch0×2, ch1×2 under RR;
- order ch0×6, ch1×6 under fixed priority.
REQ-036 Push and pop on ch3 in the same cycle at level 1 -> level stays 1, no ovf.
REQ-037 Assert reset after 2 of 5 pops -> next cycle ready=0, emptyArray=4'hf, readdata=0.
